seg7_display_ctrl: RTL and testbench



---
 rtl/seg7_display_ctrl.sv | 109 ++++++++++
 tb/tb_seg7_display_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment digits with per-digit decode/raw/blank/blink,
// global enable and 4-bit brightness PWM; registered segment outputs and read data.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 25000000,
  parameter int ADDR_W     = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_DIGITS*7-1:0] hex_out
);

  localparam int                      BW         = $clog2(BLINK_DIV);
  localparam logic [BW-1:0]           BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [ADDR_W-1:0]       CTRL_ADDR  = ADDR_W'(NUM_DIGITS);
  localparam logic [NUM_DIGITS*7-1:0] HEX_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [13:0]             digit_q [NUM_DIGITS];
  logic                    en_q;
  logic [3:0]              bright_q;
  logic [BW-1:0]           blink_cnt_q;
  logic                    phase_q;
  logic [3:0]              pwm_cnt_q;
  logic [31:0]             rdata_q, rdata_d;
  logic [NUM_DIGITS*7-1:0] hex_q, hex_d;
  logic                    wr_en, rd_en, pwm_on;
  logic                    unused_wdata;

  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read;
  assign pwm_on       = (bright_q == 4'hF) | (pwm_cnt_q < bright_q);
  assign unused_wdata = ^writedata[31:14];
  assign readdata     = rdata_q;
  assign hex_out      = hex_q;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h3F;  4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;  4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;  4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;  4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;  4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;  4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;  4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;  default: hex_decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (address == ADDR_W'(i)) rdata_d = {18'd0, digit_q[i]};
    if (address == CTRL_ADDR) rdata_d = {23'd0, phase_q, bright_q, 3'd0, en_q};
  end

  // Digit fields: [3:0] nibble, [10:4] raw, [11] raw mode, [12] blank, [13] blink.
  always_comb begin
    logic [6:0] pat;
    hex_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pat = digit_q[i][11] ? digit_q[i][10:4] : hex_decode(digit_q[i][3:0]);
      if (!en_q || digit_q[i][12] || (digit_q[i][13] && phase_q) || !pwm_on) pat = 7'h00;
      hex_d[7*i +: 7] = (ACTIVE_LOW != 0) ? ~pat : pat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 14'h1000;
      en_q     <= 1'b1;
      bright_q <= 4'hF;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (address == ADDR_W'(i)) digit_q[i] <= writedata[13:0];
      if (address == CTRL_ADDR) begin
        en_q     <= writedata[0];
        bright_q <= writedata[7:4];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      pwm_cnt_q   <= 4'd0;
      rdata_q     <= '0;
      hex_q       <= HEX_OFF;
    end else begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      if (rd_en) rdata_q <= rdata_d;
      hex_q <= hex_d;
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench for seg7_display_ctrl (8 digits, active-low, 4-cycle blink half-period).
module tb_seg7_display_ctrl;

  localparam logic [55:0] ALL_OFF = {56{1'b1}};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        cs, rd_stb, wr_stb;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [55:0] hex_out;

  int          n_vec = 0;
  int          n_err = 0;
  int          ecnt;
  logic [31:0] sb_q[$];
  logic        m_en;
  logic [3:0]  m_br;

  always #5 clk = ~clk;

  seg7_display_ctrl #(.NUM_DIGITS(8), .ACTIVE_LOW(1), .BLINK_DIV(4), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs), .read(rd_stb),
    .write(wr_stb), .writedata(writedata), .readdata(readdata), .hex_out(hex_out)
  );

  // Rising edges since reset release: blink phase after k edges is (k/4)&1, pwm count is k%16.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; wr_stb = 1'b1; address = a; writedata = d;
    @(negedge clk);
    cs = 1'b0; wr_stb = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    cs = 1'b1; rd_stb = 1'b1; address = a;
    sb_q.push_back(exp);
    @(negedge clk);
    cs = 1'b0; rd_stb = 1'b0;
    check_val(tag, readdata, sb_q.pop_front());
  endtask

  task automatic rd_ctrl(input string tag);
    logic ph;
    ph = ((ecnt / 4) % 2) != 0;
    rd(5'd8, {23'd0, ph, m_br, 3'd0, m_en}, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lit;
    logic ph;
    reset_n = 1'b0; cs = 1'b0; rd_stb = 1'b0; wr_stb = 1'b0; address = '0; writedata = '0;
    m_en = 1'b1; m_br = 4'hF;
    repeat (3) @(negedge clk);
    check_val("rst_hex", hex_out, ALL_OFF);
    check_val("rst_rdata", readdata, 0);
    reset_n = 1'b1;
    rd_ctrl("ctrl_rst");

    // Hex decode and 1-cycle output latency
    wr(5'd0, 32'h0);
    check_val("d0_latency", hex_out[6:0], 7'h7F);
    @(negedge clk);
    check_val("d0_hex0", hex_out[6:0], 7'h40);
    wr(5'd3, 32'hA);
    @(negedge clk);
    check_val("d3_hexA", hex_out[27:21], 7'h08);
    rd(5'd3, 32'hA, "rd_d3");

    // Raw mode then blank
    wr(5'd1, 32'h800 | (32'h49 << 4));
    @(negedge clk);
    check_val("d1_raw", hex_out[13:7], 7'h36);
    wr(5'd1, 32'h1C90);
    @(negedge clk);
    check_val("d1_blank", hex_out[13:7], 7'h7F);
    rd(5'd1, 32'h1C90, "rd_d1");
    wr(5'd4, 32'hFFFF_FFFF);
    rd(5'd4, 32'h3FFF, "rd_d4_mask");

    // Same-cycle read and write returns the old value
    cs = 1'b1; rd_stb = 1'b1; wr_stb = 1'b1; address = 5'd5; writedata = 32'h1005;
    sb_q.push_back(32'h1000);
    @(negedge clk);
    cs = 1'b0; rd_stb = 1'b0; wr_stb = 1'b0;
    check_val("rw_old", readdata, sb_q.pop_front());
    rd(5'd5, 32'h1005, "rw_new");

    // Blink on digit 2
    wr(5'd2, 32'h2008);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      ph = (((ecnt - 1) / 4) % 2) != 0;
      check_val("blink_d2", hex_out[20:14], ph ? 7'h7F : 7'h00);
      @(negedge clk);
    end
    rd_ctrl("ctrl_ph_a");
    rd(5'd7, 32'h1000, "rd_d7");
    rd(5'd7, 32'h1000, "rd_d7b");
    rd_ctrl("ctrl_ph_b");

    // PWM brightness 4 on digit 0 showing 8
    wr(5'd0, 32'h8);
    wr(5'd8, 32'h41); m_br = 4'h4;
    @(negedge clk);
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      check_val("pwm4", hex_out[6:0], (((ecnt - 1) % 16) < 4) ? 7'h00 : 7'h7F);
      if (hex_out[6:0] == 7'h00) lit++;
      @(negedge clk);
    end
    check_val("pwm4_count", lit, 4);
    rd_ctrl("ctrl_br4");
    wr(5'd8, 32'h01); m_br = 4'h0;
    @(negedge clk);
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      if (hex_out[6:0] != 7'h7F) lit++;
      @(negedge clk);
    end
    check_val("pwm0_count", lit, 0);
    wr(5'd8, 32'hF0); m_en = 1'b0; m_br = 4'hF;
    @(negedge clk);
    check_val("disabled", hex_out, ALL_OFF);
    rd_ctrl("ctrl_dis");
    wr(5'd8, 32'hF1); m_en = 1'b1;
    @(negedge clk);
    check_val("reenabled", hex_out[6:0], 7'h00);

    // Asynchronous reset with a read in flight
    cs = 1'b1; rd_stb = 1'b1; address = 5'd4;
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_rdata", readdata, 0);
    check_val("arst_hex", hex_out, ALL_OFF);
    cs = 1'b0; rd_stb = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_en = 1'b1; m_br = 4'hF;
    rd(5'd4, 32'h1000, "rd_d4_rst");
    rd_ctrl("ctrl_after_rst");

    // Out-of-range addresses
    wr(5'd9, 32'hFFFF_FFFF);
    wr(5'd31, 32'h0000_0000);
    for (int a = 0; a < 8; a++) rd(5'(a), 32'h1000, "oob_digit");
    rd_ctrl("oob_ctrl");
    rd(5'd9, 32'h0, "rd_a9");
    rd(5'd31, 32'h0, "rd_a31");
    check_val("oob_hex", hex_out, ALL_OFF);
    check_val("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
